booth_r4_seq: RTL and testbench

- Sequential radix-4 Booth signed multiplier controller and accumulator for the multiplier datapath.
- Sits directly upstream and downstream of mux_five_to_one.
  - It drives the mux select `op`.
  - It consumes the selected 16-bit partial product `saida`.
- Top level builds the five mux candidates from `multiplicand_q`: a=0, b=+M, c=+2M, d=−M, e=−2M, each sign-extended to 2N bits.
- Produces one N×N signed product in N/2 accumulation cycles.

---
 rtl/mult_pkg.sv | 19 +
 rtl/booth_recoder.sv | 25 ++
 rtl/booth_r4_seq.sv | 107 ++++++++++
 tb/tb_booth_r4_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath: mux select codes,
// controller state encoding and the default operand width.
package mult_pkg;

  localparam int N_DEFAULT = 8;

  localparam logic [2:0] OP_ZERO   = 3'd0;
  localparam logic [2:0] OP_POS_M  = 3'd1;
  localparam logic [2:0] OP_POS_2M = 3'd2;
  localparam logic [2:0] OP_NEG_M  = 3'd3;
  localparam logic [2:0] OP_NEG_2M = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {q[i+1], q[i], q[i-1]}
// onto the mux_five_to_one select code.
module booth_recoder
  import mult_pkg::*;
(
  input  logic [2:0] window,
  output logic [2:0] op
);

  always_comb begin
    op = OP_ZERO;
    case (window)
      3'b000:  op = OP_ZERO;
      3'b001:  op = OP_POS_M;
      3'b010:  op = OP_POS_M;
      3'b011:  op = OP_POS_2M;
      3'b100:  op = OP_NEG_2M;
      3'b101:  op = OP_NEG_M;
      3'b110:  op = OP_NEG_M;
      3'b111:  op = OP_ZERO;
      default: op = OP_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq.sv
// Sequential radix-4 Booth signed multiplier controller and accumulator.
// Optional macro BOOTH_EARLY_EXIT_EN ends RUN once all remaining digits are zero.
module booth_r4_seq
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic [2*N-1:0] saida,
  output logic [2:0]     op,
  output logic [N-1:0]   multiplicand_q,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [1:0]     state
);

  localparam int CNT_W = (N / 2 > 1) ? $clog2(N / 2) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N / 2 - 1);

  state_t state_q;
  state_t state_d;

  logic [N:0]       qreg;
  logic [N:0]       qreg_shift;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   acc_next;
  logic [2*N-1:0]   saida_weighted;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       rec_op;
  logic             finish;

  booth_recoder u_recoder (
    .window (qreg[2:0]),
    .op     (rec_op)
  );

  // Digit cnt carries weight 4^cnt, so the partial product shifts by 2*cnt.
  assign saida_weighted = saida << {cnt, 1'b0};
  assign acc_next       = acc + saida_weighted;
  assign qreg_shift     = $signed(qreg) >>> 2;

`ifdef BOOTH_EARLY_EXIT_EN
  // A uniform remaining qreg only yields 000/111 windows, i.e. zero digits.
  assign finish = (cnt == CNT_LAST) || (&qreg_shift) || (~|qreg_shift);
`else
  assign finish = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (finish) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      multiplicand_q <= '0;
      qreg           <= '0;
      acc            <= '0;
      cnt            <= '0;
      product        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            multiplicand_q <= multiplicand;
            qreg           <= {multiplier, 1'b0};
            acc            <= '0;
            cnt            <= '0;
          end
        end
        RUN: begin
          acc  <= acc_next;
          qreg <= qreg_shift;
          cnt  <= cnt + 1'b1;
          if (finish) begin
            product <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign op    = (state_q == RUN) ? rec_op : OP_ZERO;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: tb/tb_booth_r4_seq.sv
// Self-checking bench for booth_r4_seq: directed and random multiplies against
// an arithmetic Booth-digit model, with a behavioural mux_five_to_one in the loop.
module tb_booth_r4_seq;
  import mult_pkg::*;

  localparam int N = 8;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] saida;
  logic [2:0]     op;
  logic [N-1:0]   multiplicand_q;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic [1:0]     state;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  booth_r4_seq #(.N(N)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .multiplicand   (multiplicand),
    .multiplier     (multiplier),
    .saida          (saida),
    .op             (op),
    .multiplicand_q (multiplicand_q),
    .busy           (busy),
    .done           (done),
    .product        (product),
    .state          (state)
  );

  always #5 clock = ~clock;

  // Behavioural five-way candidate mux fed from the latched multiplicand.
  logic signed [2*N-1:0] m_ext;
  always_comb begin
    m_ext = $signed(multiplicand_q);
    saida = '0;
    case (op)
      3'd0: saida = '0;
      3'd1: saida = m_ext;
      3'd2: saida = m_ext * 2;
      3'd3: saida = -m_ext;
      3'd4: saida = -(m_ext * 2);
      default: saida = 'x;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Booth digit i of q: -2*q[2i+1] + q[2i] + q[2i-1], with q[-1] = 0.
  function automatic int booth_digit(input logic [N-1:0] q, input int i);
    logic [N:0] qe;
    qe = {q, 1'b0};
    return -2 * int'(qe[2*i+2]) + int'(qe[2*i+1]) + int'(qe[2*i]);
  endfunction

  function automatic logic [2:0] digit_op(input int d);
    case (d)
      1:       return 3'd1;
      2:       return 3'd2;
      -1:      return 3'd3;
      -2:      return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [N-1:0] q);
    int last;
    last = 0;
    for (int i = 0; i < N / 2; i++) begin
      if (booth_digit(q, i) != 0) last = i + 1;
    end
`ifdef BOOTH_EARLY_EXIT_EN
    return (last == 0) ? 1 : last;
`else
    return N / 2;
`endif
  endfunction

  task automatic do_mult(input logic [N-1:0] m, input logic [N-1:0] q, input bit poke_start);
    logic signed [2*N-1:0] ms;
    logic signed [2*N-1:0] qs;
    logic [2*N-1:0] exp_p;
    logic [2:0] eop;
    int lat;
    int busy_cycles;
    int cyc;
    bit got_done;
    ms = $signed(m);
    qs = $signed(q);
    exp_p = 16'(ms * qs);
    exp_q.delete();
    for (int i = 0; i < N / 2; i++) exp_q.push_back(digit_op(booth_digit(q, i)));
    lat = exp_latency(q);

    @(posedge clock); #1;
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    @(posedge clock); #1;
    start = poke_start;
    multiplicand = poke_start ? 8'd1 : 8'($urandom);
    multiplier = poke_start ? 8'd1 : 8'($urandom);

    busy_cycles = 0;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 16) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (busy) begin
        busy_cycles++;
        if (exp_q.size() > 0) begin
          eop = exp_q.pop_front();
          check_eq("op_run", op, eop);
        end
      end
      if (done) got_done = 1'b1;
    end
    check_eq("done_seen", got_done, 1);
    check_eq("latency", busy_cycles, lat);
    check_eq("product", product, exp_p);
    check_eq("busy_at_done", busy, 0);
    check_eq("op_at_done", op, 0);
    @(negedge clock);
    check_eq("done_one_pulse", done, 0);
    check_eq("busy_after", busy, 0);
    check_eq("product_held", product, exp_p);
    check_eq("state_idle", state, IDLE);
  endtask

  task automatic reset_mid_run();
    @(posedge clock); #1;
    start = 1'b1;
    multiplicand = 8'd3;
    multiplier = 8'd5;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_op", op, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_product", product, 0);
    check_eq("rst_mq", multiplicand_q, 0);
    check_eq("rst_state", state, IDLE);
    repeat (3) begin
      @(negedge clock);
      check_eq("rst_no_done", done, 0);
    end
    reset_n = 1'b1;
    do_mult(8'd3, 8'd5, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clock);
    check_eq("reset_op", op, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_product", product, 0);
    check_eq("reset_mq", multiplicand_q, 0);
    check_eq("reset_state", state, IDLE);
    reset_n = 1'b1;

    do_mult(8'd3, 8'd5, 1'b0);
    do_mult(8'hF9, 8'd6, 1'b0);
    do_mult(8'h80, 8'h80, 1'b0);
    do_mult(8'h7F, 8'h80, 1'b0);
    do_mult(8'h7F, 8'h7F, 1'b0);
    do_mult(8'hFF, 8'hFF, 1'b0);
    do_mult(8'd9, 8'd0, 1'b0);
    do_mult(8'h00, 8'h55, 1'b0);
    do_mult(8'd3, 8'd5, 1'b1);
    reset_mid_run();
    for (int i = 0; i < 40; i++) begin
      do_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
